// File: rtl/pwm_fade_sequencer.sv
// Eight-channel PWM brightness register bank. On each frame tick, one shared
// step/compare datapath moves one channel per cycle toward its programmed target.
module pwm_fade_sequencer #(
    parameter int NCH    = 8,
    parameter int DW     = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [4:0]        rd_addr,
    output logic [7:0]        rd_data,
    output logic [NCH*DW-1:0] pwm_val,
    output logic              busy,
    output logic              done
);

    localparam int IW = $clog2(NCH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state_q;
    logic [IW-1:0]     idx_q;
    logic [DW-1:0]     target_q  [NCH];
    logic [DW-1:0]     current_q [NCH];
    logic [STEP_W-1:0] step_q;
    logic              en_q;
    logic              overrun_q;
    logic              done_q;

    logic [DW-1:0]     sel_cur_d;
    logic [DW-1:0]     sel_tgt_d;
    logic [DW-1:0]     step_ext_d;
    logic [DW:0]       sum_d;
    logic [DW:0]       floor_d;
    logic [DW-1:0]     upd_val_d;
    logic [NCH-1:0]    match_d;
    logic              settled_d;
    logic              last_ch_d;

    // Step/compare datapath, shared by all channels through idx_q
    always_comb begin
        sel_cur_d  = current_q[idx_q];
        sel_tgt_d  = target_q[idx_q];
        step_ext_d = {{(DW-STEP_W){1'b0}}, step_q};
        sum_d      = {1'b0, sel_cur_d} + {1'b0, step_ext_d};
        floor_d    = {1'b0, sel_tgt_d} + {1'b0, step_ext_d};
        upd_val_d  = sel_cur_d;
        if (step_q == '0) begin
            upd_val_d = sel_tgt_d;
        end else if (sel_cur_d < sel_tgt_d) begin
            upd_val_d = (sum_d > {1'b0, sel_tgt_d}) ? sel_tgt_d : sum_d[DW-1:0];
        end else if (sel_cur_d > sel_tgt_d) begin
            // cur - step would land below target (or underflow): clamp to target
            upd_val_d = ({1'b0, sel_cur_d} < floor_d) ? sel_tgt_d : (sel_cur_d - step_ext_d);
        end
        last_ch_d = (idx_q == IW'(NCH - 1));
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_lane
            assign pwm_val[gi*DW +: DW] = current_q[gi];
            assign match_d[gi]          = (current_q[gi] == target_q[gi]);
        end
    endgenerate

    assign settled_d = &match_d;
    assign busy      = (state_q == SCAN);
    assign done      = done_q;

    always_comb begin
        rd_data = '0;
        if (rd_addr[4:3] == 2'b00) begin
            rd_data = target_q[rd_addr[2:0]];
        end else if (rd_addr[4:3] == 2'b01) begin
            rd_data = current_q[rd_addr[2:0]];
        end else begin
            case (rd_addr)
                5'h10:   rd_data = {{(8-STEP_W){1'b0}}, step_q};
                5'h11:   rd_data = {7'b0, en_q};
                5'h12:   rd_data = {5'b0, settled_d, overrun_q, busy};
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            step_q    <= STEP_W'(1);
            en_q      <= 1'b0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                target_q[i]  <= '0;
                current_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;

            if (wr_en) begin
                if (wr_addr[4:3] == 2'b00) begin
                    target_q[wr_addr[2:0]] <= wr_data;
                end else if (wr_addr[4:3] == 2'b01) begin
                    current_q[wr_addr[2:0]] <= wr_data;
                end else begin
                    case (wr_addr)
                        5'h10:   step_q <= wr_data[STEP_W-1:0];
                        5'h11:   en_q   <= wr_data[0];
                        5'h12:   if (wr_data[1]) overrun_q <= 1'b0;
                        default: ;
                    endcase
                end
            end

            // Placed after the clear so a dropped tick wins over a same-edge clear
            if (state_q == SCAN && tick) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (tick && en_q) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                    end
                end
                SCAN: begin
                    if (!en_q) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end else if (!wr_en) begin
                        current_q[idx_q] <= upd_val_d;
                        if (last_ch_d) begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
